counter_sequencer: RTL and testbench

//  Command-driven controller that sequences the shared up-counter (WIDTH-bit, enable input, Q output).

---
 rtl/counter_sequencer_pkg.sv | 19 +
 rtl/counter_sequencer_if.sv | 18 +
 rtl/counter_sequencer.sv | 138 +++++++++++++
 tb/tb_counter_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: command op codes and FSM states.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_PAUSE  = 2'd1,
    OP_RESUME = 2'd2,
    OP_ABORT  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command channel of the counter sequencer: valid/ready handshake plus payload.
interface counter_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAPW  = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_target;
  logic [LAPW-1:0]  cmd_laps;

  modport master (output cmd_valid, cmd_op, cmd_target, cmd_laps, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_target, cmd_laps, output cmd_ready);

endinterface

// File: rtl/counter_sequencer.sv
// Command-driven controller for an external WIDTH-bit up-counter. Runs the
// counter for laps*2^WIDTH+target increments, supports pause/resume/abort,
// and shadow-checks the counter output while a run is in progress.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAPW  = 4
) (
  input  logic                clk,
  input  logic                rstb,
  counter_sequencer_if.slave  cmd,
  output logic                cnt_en,
  output logic                cnt_clr,
  input  logic [WIDTH-1:0]    cnt_q,
  output logic                busy,
  output logic                done,
  output logic                cmd_err,
  output logic                chk_err
);

  localparam int RW = LAPW + WIDTH;

  state_t           r_state;
  state_t           w_state_next;
  logic [RW-1:0]    r_remaining;
  logic [RW-1:0]    w_remaining_next;
  logic [RW-1:0]    w_rem_dec;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_next;
  logic             r_cnt_en;
  logic             r_cnt_clr;
  logic             r_cmd_err;
  logic             w_cmd_err_next;
  logic             r_chk_err;
  logic             w_start;
  logic             w_accept;
  logic             w_mismatch;

  assign w_accept = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state, run bookkeeping and command legality.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_shadow_next    = r_shadow;
    w_cmd_err_next   = 1'b0;
    w_start          = 1'b0;
    w_rem_dec        = r_cnt_en ? (r_remaining - RW'(1)) : r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd.cmd_op == OP_START) begin
            w_state_next     = ST_CLEAR;
            // Concatenation is exactly laps*2^WIDTH + target.
            w_remaining_next = {cmd.cmd_laps, cmd.cmd_target};
            w_shadow_next    = '0;
            w_start          = 1'b1;
          end else begin
            w_cmd_err_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        w_state_next = (r_remaining == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        w_remaining_next = w_rem_dec;
        w_shadow_next    = r_shadow + {{(WIDTH-1){1'b0}}, r_cnt_en};
        if (w_rem_dec == '0) begin
          // Completion wins over any command arriving on the final increment.
          w_state_next   = ST_DONE;
          w_cmd_err_next = w_accept;
        end else if (w_accept) begin
          case (cmd.cmd_op)
            OP_PAUSE: w_state_next = ST_PAUSED;
            OP_ABORT: begin
              w_state_next     = ST_IDLE;
              w_remaining_next = '0;
            end
            default:  w_cmd_err_next = 1'b1;
          endcase
        end
      end
      ST_PAUSED: begin
        if (w_accept) begin
          case (cmd.cmd_op)
            OP_RESUME: w_state_next = ST_RUN;
            OP_ABORT: begin
              w_state_next     = ST_IDLE;
              w_remaining_next = '0;
            end
            default:   w_cmd_err_next = 1'b1;
          endcase
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Counter output is only meaningful while a run owns the counter.
  assign w_mismatch = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && (cnt_q != r_shadow);

  // State, bookkeeping and registered counter controls.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_shadow    <= '0;
      r_cnt_en    <= 1'b0;
      r_cnt_clr   <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_chk_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_shadow    <= w_shadow_next;
      r_cnt_en    <= (w_state_next == ST_RUN) && (w_remaining_next != '0);
      r_cnt_clr   <= (w_state_next == ST_CLEAR);
      r_cmd_err   <= w_cmd_err_next;
      r_chk_err   <= w_start ? 1'b0 : (r_chk_err | w_mismatch);
    end
  end

  assign cnt_en        = r_cnt_en;
  assign cnt_clr       = r_cnt_clr;
  assign cmd_err       = r_cmd_err;
  assign chk_err       = r_chk_err;
  assign done          = (r_state == ST_DONE);
  assign busy          = (r_state == ST_CLEAR) || (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign cmd.cmd_ready = !((r_state == ST_CLEAR) || (r_state == ST_DONE));

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer, with a real up-counter beside it.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int LAPW  = 4;
  localparam int MODV  = 1 << WIDTH;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WIDTH(WIDTH), .LAPW(LAPW)) cmd_bus ();

  logic             cnt_en, cnt_clr, busy, done, cmd_err, chk_err;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] fault_mask = '0;
  logic [WIDTH-1:0] w_q_seen;

  assign w_q_seen = r_q ^ fault_mask;

  counter_sequencer #(.WIDTH(WIDTH), .LAPW(LAPW)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .cmd     (cmd_bus.slave),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .cnt_q   (w_q_seen),
    .busy    (busy),
    .done    (done),
    .cmd_err (cmd_err),
    .chk_err (chk_err)
  );

  // The shared up-counter driven by the sequencer.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        r_q <= '0;
    else if (cnt_clr) r_q <= '0;
    else if (cnt_en)  r_q <= r_q + 1'b1;
  end

  // Running event totals, sampled mid-cycle.
  int en_total = 0, clr_total = 0, done_total = 0, err_total = 0;
  int q_at_done = -1;
  always @(negedge clk) begin
    en_total   += int'(cnt_en);
    clr_total  += int'(cnt_clr);
    done_total += int'(done);
    err_total  += int'(cmd_err);
    if (done) q_at_done = int'(r_q);
  end

  int checks = 0, errors = 0;
  int en_base, clr_base, done_base, err_base;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    en_base   = en_total;
    clr_base  = clr_total;
    done_base = done_total;
    err_base  = err_total;
  endtask

  // Present a command, wait (bounded) for ready, let it be accepted on one edge.
  task automatic send(input op_t op, input int tgt, input int laps);
    int guard = 0;
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_op     = op;
    cmd_bus.cmd_target = tgt[WIDTH-1:0];
    cmd_bus.cmd_laps   = laps[LAPW-1:0];
    while (!cmd_bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("cmd_ready_seen", cmd_bus.cmd_ready, 1);
    tick();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Wait until the enabled-cycle count since snapshot reaches n with cnt_en high.
  task automatic wait_en(input int n);
    int guard = 0;
    while (!(cnt_en && (en_total - en_base) == n) && guard < 400) begin
      tick();
      guard++;
    end
    check("wait_en_reached", en_total - en_base, n);
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!done && lat < budget) begin
      tick();
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  // Reference: a run is laps full wraps plus target increments.
  function automatic int model_n(input int tgt, input int laps);
    return laps * MODV + tgt;
  endfunction

  task automatic run_case(input int tgt, input int laps, input int pause_at, input int idle);
    int n, lat;
    n = model_n(tgt, laps);
    snapshot();
    send(OP_START, tgt, laps);
    check("clear_pulse", cnt_clr, 1);
    check("clear_no_en", cnt_en, 0);
    if (pause_at > 0) begin
      wait_en(pause_at - 1);
      send(OP_PAUSE, 0, 0);
      check("paused_en_low", cnt_en, 0);
      check("paused_busy", busy, 1);
      check("paused_q", r_q, pause_at % MODV);
      repeat (idle) tick();
      check("paused_hold_q", r_q, pause_at % MODV);
      send(OP_RESUME, 0, 0);
      check("resume_en_high", cnt_en, 1);
    end
    wait_done(n + 60, lat);
    if (pause_at == 0) check("done_latency", lat, n + 1);
    tick();
    tick();
    check("en_cycles", en_total - en_base, n);
    check("clr_cycles", clr_total - clr_base, 1);
    check("done_pulses", done_total - done_base, 1);
    check("q_at_done", q_at_done, n % MODV);
    check("chk_err_clean", chk_err, 0);
    check("no_cmd_err", err_total - err_base, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int lat;
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_op     = OP_START;
    cmd_bus.cmd_target = '0;
    cmd_bus.cmd_laps   = '0;

    // Reset values.
    #1;
    check("rst_cmd_ready", cmd_bus.cmd_ready, 1);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_chk_err", chk_err, 0);
    @(negedge clk);
    rstb = 1'b1;
    tick();

    // Directed runs: short, one wrap, empty, paused.
    run_case(5, 0, 0, 0);
    run_case(3, 1, 0, 0);
    run_case(0, 0, 0, 0);
    run_case(10, 0, 4, 7);

    // ABORT mid-run: no done, counter stays where it stopped.
    snapshot();
    send(OP_START, 4, 1);
    wait_en(6);
    send(OP_ABORT, 0, 0);
    check("abort_idle", busy, 0);
    check("abort_en_low", cnt_en, 0);
    repeat (30) tick();
    check("abort_no_done", done_total - done_base, 0);
    check("abort_en_cycles", en_total - en_base, 7);
    check("abort_q_kept", r_q, 7);

    // Illegal command in IDLE.
    snapshot();
    send(OP_PAUSE, 0, 0);
    check("idle_pause_err", cmd_err, 1);
    check("idle_pause_stays", busy, 0);
    tick();
    check("err_is_pulse", cmd_err, 0);

    // START while running is dropped; the run continues untouched.
    snapshot();
    send(OP_START, 8, 0);
    wait_en(3);
    send(OP_START, 2, 0);
    check("run_start_err", cmd_err, 1);
    check("run_start_busy", busy, 1);
    wait_done(60, lat);
    tick();
    check("run_start_en", en_total - en_base, 8);
    check("run_start_q", q_at_done, 8);

    // PAUSE on the final increment: completion wins, PAUSE reported as error.
    snapshot();
    send(OP_START, 6, 0);
    wait_en(5);
    send(OP_PAUSE, 0, 0);
    check("collide_done", done, 1);
    check("collide_err", cmd_err, 1);
    tick();
    check("collide_en", en_total - en_base, 6);
    check("collide_q", q_at_done, 6);

    // Corrupted counter output: sticky chk_err until the next START.
    snapshot();
    send(OP_START, 12, 0);
    wait_en(5);
    fault_mask = 4'b0100;
    tick();
    fault_mask = '0;
    check("fault_flagged", chk_err, 1);
    wait_done(60, lat);
    repeat (3) tick();
    check("fault_sticky", chk_err, 1);
    send(OP_START, 2, 0);
    check("fault_cleared", chk_err, 0);
    wait_done(60, lat);
    tick();

    // Reset mid-run: outputs drop immediately, no done afterwards.
    snapshot();
    send(OP_START, 0, 3);
    wait_en(10);
    #2;
    rstb = 1'b0;
    #1;
    check("mid_rst_en", cnt_en, 0);
    check("mid_rst_clr", cnt_clr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_bus.cmd_ready, 1);
    check("mid_rst_chk", chk_err, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (60) tick();
    check("mid_rst_no_done", done_total - done_base, 0);

    // Randomized runs against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      int tgt, laps, n, pause_at, idle;
      tgt  = int'($urandom_range(0, 15));
      laps = int'($urandom_range(0, 3));
      n    = model_n(tgt, laps);
      pause_at = 0;
      idle     = 0;
      if (n >= 2 && $urandom_range(0, 1) == 1) begin
        pause_at = int'($urandom_range(1, n - 1));
        idle     = int'($urandom_range(0, 9));
      end
      run_case(tgt, laps, pause_at, idle);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
